exec_muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the RV64 execute stage. It implements the M-extension operations, including the W variants, for any `DATA_WIDTH`, and is sequenced by a small FSM. While an operation is in flight it stalls the pipeline. It sits beside the single-cycle ALU, takes already-forwarded operands, and delivers its result with a valid strobe for the execute pipeline register.

---
 rtl/exec_muldiv_unit.sv | 195 +++++++++++++++++++
 tb/tb_exec_muldiv_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/exec_muldiv_unit.sv
// exec_muldiv_unit -- iterative RV64 M-extension multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle,
// sequenced by an IDLE/CALC/DONE FSM. Stalls the pipeline while busy.
// Ports:
//   i_clk, i_arst       clock, synchronous active-high reset
//   i_valid, i_op       M instruction present, func3 operation code
//   i_word              W variant (MULW/DIVW/DIVUW/REMW/REMUW)
//   i_src_1, i_src_2    forwarded rs1 / rs2 operands
//   i_rd_addr           destination register
//   i_flush             kill the operation in flight
//   o_stall             hold fetch/decode/execute
//   o_valid, o_result   one-cycle result strobe and registered result
//   o_rd_addr           destination register latched at accept
module exec_muldiv_unit #(
   parameter int DATA_WIDTH = 64,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic                  i_valid,
   input  logic [2:0]            i_op,
   input  logic                  i_word,
   input  logic [DATA_WIDTH-1:0] i_src_1,
   input  logic [DATA_WIDTH-1:0] i_src_2,
   input  logic [REG_ADDR_W-1:0] i_rd_addr,
   input  logic                  i_flush,
   output logic                  o_stall,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_result,
   output logic [REG_ADDR_W-1:0] o_rd_addr
);
   localparam int          W  = DATA_WIDTH;
   localparam int unsigned UW = DATA_WIDTH;
   localparam int          CW = $clog2(DATA_WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]            r_state;
   logic [CW-1:0]         r_cnt;
   logic [2:0]            r_op;
   logic                  r_word;
   logic                  r_s1;      // rs1 (dividend) negative
   logic                  r_sx;      // operand signs differ
   logic [W-1:0]          r_hi;      // product high / partial remainder
   logic [W-1:0]          r_lo;      // product low / dividend-quotient shifter
   logic [2*W-1:0]        r_x;       // shifted multiplicand
   logic [W-1:0]          r_y;       // multiplier shifter / divisor
   logic [W-1:0]          r_result;
   logic [REG_ADDR_W-1:0] r_rd;

   // sign-extend bits [31:0] to full width in word mode
   function automatic logic [W-1:0] f_fin(input logic [W-1:0] x, input logic wd);
      logic [W-1:0] y;
      y = x;
      if (wd) begin
         for (int unsigned k = 32; k < UW; k++) y[k] = x[31];
      end
      return y;
   endfunction

   // ---------------- accept-cycle operand preparation ----------------
   logic         w_word, w_sgn1, w_sgn2, w_neg1, w_neg2;
   logic [W-1:0] w_a, w_b, w_mag1, w_mag2, w_minneg, w_spec_res;
   logic         w_div0, w_ovf, w_special;

   always_comb begin
      // word mode only applies to MULW and the divide ops
      w_word = i_word && (W > 32) && (i_op[2] || i_op[1:0] == 2'b00);
      w_sgn1 = 1'b1;
      w_sgn2 = 1'b1;
      case (i_op)
         3'd2:                   w_sgn2 = 1'b0;
         3'd3, 3'd5, 3'd7: begin w_sgn1 = 1'b0; w_sgn2 = 1'b0; end
         default: ;
      endcase
      w_a      = i_src_1;
      w_b      = i_src_2;
      w_minneg = '0;
      w_minneg[W-1] = 1'b1;
      if (w_word) begin
         for (int unsigned k = 32; k < UW; k++) begin
            w_a[k]      = w_sgn1 & i_src_1[31];
            w_b[k]      = w_sgn2 & i_src_2[31];
            w_minneg[k] = 1'b1;
         end
         w_minneg[31] = 1'b1;
      end
      w_neg1 = w_sgn1 & w_a[W-1];
      w_neg2 = w_sgn2 & w_b[W-1];
      w_mag1 = w_neg1 ? -w_a : w_a;
      w_mag2 = w_neg2 ? -w_b : w_b;
      w_div0 = (w_b == '0);
      w_ovf  = w_sgn1 && (w_a == w_minneg) && (w_b == '1);
      w_special = i_op[2] & (w_div0 | w_ovf);
      if (w_div0) w_spec_res = i_op[1] ? w_a : '1;
      else        w_spec_res = i_op[1] ? '0  : w_a;
      w_spec_res = f_fin(w_spec_res, w_word);
   end

   // ---------------- one iteration and final result ----------------
   logic [2*W-1:0] w_prod_nxt, w_prod_sgn;
   logic [W:0]     w_rsh, w_rsub;
   logic           w_ge;
   logic [W-1:0]   w_hi_nxt, w_lo_nxt, w_quo, w_rem, w_fin_res;

   always_comb begin
      w_prod_nxt = {r_hi, r_lo} + (r_y[0] ? r_x : '0);
      w_rsh      = {r_hi, r_lo[W-1]};
      w_rsub     = w_rsh - {1'b0, r_y};
      w_ge       = (w_rsh >= {1'b0, r_y});
      if (r_op[2]) begin
         w_hi_nxt = w_ge ? w_rsub[W-1:0] : w_rsh[W-1:0];
         w_lo_nxt = {r_lo[W-2:0], w_ge};
      end else begin
         w_hi_nxt = w_prod_nxt[2*W-1:W];
         w_lo_nxt = w_prod_nxt[W-1:0];
      end
      w_prod_sgn = r_sx ? -{w_hi_nxt, w_lo_nxt} : {w_hi_nxt, w_lo_nxt};
      w_quo      = r_sx ? -w_lo_nxt : w_lo_nxt;
      w_rem      = r_s1 ? -w_hi_nxt : w_hi_nxt;
      if (r_op[2])                 w_fin_res = f_fin(r_op[1] ? w_rem : w_quo, r_word);
      else if (r_op[1:0] == 2'b00) w_fin_res = f_fin(w_prod_sgn[W-1:0], r_word);
      else                         w_fin_res = w_prod_sgn[2*W-1:W];
   end

   // ---------------- sequencing ----------------
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_op     <= '0;
         r_word   <= 1'b0;
         r_s1     <= 1'b0;
         r_sx     <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_result <= '0;
         r_rd     <= '0;
      end else if (i_flush) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (i_valid) begin
               r_op   <= i_op;
               r_word <= w_word;
               r_s1   <= w_neg1;
               r_sx   <= w_neg1 ^ w_neg2;
               r_rd   <= i_rd_addr;
               r_hi   <= '0;
               r_y    <= w_mag2;
               if (i_op[2]) begin
                  // word divide: align the 32-bit dividend to the MSB so
                  // N=32 shifts consume exactly its bits
                  r_lo <= w_word ? (w_mag1 << (W - 32)) : w_mag1;
                  r_x  <= '0;
               end else begin
                  r_lo <= '0;
                  r_x  <= {{W{1'b0}}, w_mag1};
               end
               if (w_special) begin
                  r_result <= w_spec_res;
                  r_state  <= S_DONE;
               end else begin
                  r_cnt   <= w_word ? CW'(32) : CW'(W);
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_hi  <= w_hi_nxt;
               r_lo  <= w_lo_nxt;
               r_x   <= r_x << 1;
               r_y   <= r_op[2] ? r_y : (r_y >> 1);
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_result <= w_fin_res;
                  r_state  <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_stall   = ~i_arst & ~i_flush &
                      (((r_state == S_IDLE) & i_valid) | (r_state == S_CALC));
   assign o_valid   = ~i_arst & ~i_flush & (r_state == S_DONE);
   assign o_result  = r_result;
   assign o_rd_addr = r_rd;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Directed bench for exec_muldiv_unit: latency, results, special cases,
// flush and reset behaviour with hand-computed expected values.
module tb_exec_muldiv_unit;
   logic        clk = 1'b0;
   logic        arst, valid, word, flush;
   logic [2:0]  op;
   logic [63:0] src1, src2;
   logic [4:0]  rd;
   logic        stall, ovalid;
   logic [63:0] result;
   logic [4:0]  ord;

   int total = 0;
   int bad   = 0;

   exec_muldiv_unit #(.DATA_WIDTH(64), .REG_ADDR_W(5)) dut (
      .i_clk(clk), .i_arst(arst), .i_valid(valid), .i_op(op), .i_word(word),
      .i_src_1(src1), .i_src_2(src2), .i_rd_addr(rd), .i_flush(flush),
      .o_stall(stall), .o_valid(ovalid), .o_result(result), .o_rd_addr(ord)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Issue one op in the current (IDLE) cycle, wait for o_valid, check it.
   task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] r,
                         input int lat, input logic [63:0] exp);
      int cyc;
      bit stall_ok;
      op = o; word = w; src1 = a; src2 = b; rd = r; valid = 1'b1;
      #1;
      chk({tag, "_stall0"}, {63'd0, stall}, 64'd1);
      cyc = 0;
      stall_ok = 1'b1;
      do begin
         tick();
         valid = 1'b0;
         src1 = '0; src2 = '0; rd = '0; op = '0; word = 1'b0;
         cyc++;
         if (stall !== ~ovalid) stall_ok = 1'b0;
      end while (ovalid !== 1'b1 && cyc < 200);
      chk({tag, "_lat"}, 64'(cyc), 64'(lat));
      chk({tag, "_res"}, result, exp);
      chk({tag, "_rd"}, {59'd0, ord}, {59'd0, r});
      chk({tag, "_stall"}, {63'd0, stall_ok}, 64'd1);
      tick();
      chk({tag, "_vlow"}, {63'd0, ovalid}, 64'd0);
   endtask

   initial begin
      int seen;
      arst = 1'b1; valid = 1'b0; word = 1'b0; flush = 1'b0;
      op = '0; src1 = '0; src2 = '0; rd = '0;
      tick(); tick();
      arst = 1'b0;
      #1;
      chk("rst_valid", {63'd0, ovalid}, 64'd0);
      chk("rst_stall", {63'd0, stall}, 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_rd", {59'd0, ord}, 64'd0);
      tick();

      run_op("mul",    3'd0, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 5'd3, 65, 64'hFFFFFFFFFFFFFFEB);
      run_op("mulhu",  3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd2, 5'd4, 65, 64'h1);
      run_op("mulhsu", 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd2, 5'd5, 65, 64'hFFFFFFFFFFFFFFFF);
      run_op("mulh",   3'd1, 1'b0, 64'h8000000000000000, 64'h8000000000000000, 5'd6, 65,
             64'h4000000000000000);
      run_op("div",    3'd4, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd7, 65, 64'hFFFFFFFFFFFFFFFD);
      run_op("rem",    3'd6, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd8, 65, 64'hFFFFFFFFFFFFFFFF);
      run_op("divu",   3'd5, 1'b0, 64'd100, 64'd7, 5'd9, 65, 64'd14);
      run_op("remu",   3'd7, 1'b0, 64'd100, 64'd7, 5'd10, 65, 64'd2);
      run_op("divu0",  3'd5, 1'b0, 64'd5, 64'd0, 5'd11, 1, 64'hFFFFFFFFFFFFFFFF);
      run_op("rem0",   3'd6, 1'b0, 64'd5, 64'd0, 5'd12, 1, 64'd5);
      run_op("divovf", 3'd4, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd13, 1,
             64'h8000000000000000);
      run_op("divwovf", 3'd4, 1'b1, 64'h0000000080000000, 64'hFFFFFFFFFFFFFFFF, 5'd14, 1,
             64'hFFFFFFFF80000000);
      run_op("mulw",   3'd0, 1'b1, 64'h10000, 64'h10000, 5'd15, 33, 64'd0);
      run_op("divuw",  3'd5, 1'b1, 64'h12345678FFFFFFFF, 64'd1, 5'd16, 33, 64'hFFFFFFFFFFFFFFFF);
      run_op("remw",   3'd6, 1'b1, 64'h00000000FFFFFFF9, 64'd2, 5'd17, 33, 64'hFFFFFFFFFFFFFFFF);

      // flush in cycle 10 of a DIV
      op = 3'd4; word = 1'b0; src1 = 64'd100; src2 = 64'd7; rd = 5'd20; valid = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         valid = 1'b0;
      end
      flush = 1'b1;
      #1;
      chk("flush_stall_same", {63'd0, stall}, 64'd0);
      chk("flush_valid_same", {63'd0, ovalid}, 64'd0);
      tick();
      flush = 1'b0;
      #1;
      chk("flush_stall_next", {63'd0, stall}, 64'd0);
      seen = 0;
      for (int k = 0; k < 80; k++) begin
         if (ovalid === 1'b1) seen++;
         tick();
      end
      chk("flush_no_valid", 64'(seen), 64'd0);

      // reset in cycle 20 of a DIV
      op = 3'd4; word = 1'b0; src1 = 64'd100; src2 = 64'd7; rd = 5'd21; valid = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         valid = 1'b0;
      end
      arst = 1'b1;
      #1;
      chk("arst_stall_same", {63'd0, stall}, 64'd0);
      tick();
      arst = 1'b0;
      #1;
      chk("arst_valid", {63'd0, ovalid}, 64'd0);
      chk("arst_stall", {63'd0, stall}, 64'd0);
      chk("arst_result", result, 64'd0);
      chk("arst_rd", {59'd0, ord}, 64'd0);
      seen = 0;
      for (int k = 0; k < 80; k++) begin
         if (ovalid === 1'b1) seen++;
         tick();
      end
      chk("arst_no_valid", 64'(seen), 64'd0);
      run_op("mul_after", 3'd0, 1'b0, 64'd3, 64'd5, 5'd22, 65, 64'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
